// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter slice.
// Functional-unit count and default bus widths used across the CDB logic.
package cdb_arbiter_pkg;

    // Result producers sharing the CDB: ALUs, CMP, load unit, branch unit.
    localparam int NUM_FU       = 8;
    localparam int TAG_W_DEF    = 3;
    localparam int DATA_W_DEF   = 32;

    // Width of an index into NUM_FU producers.
    localparam int SRC_W_DEF    = $clog2(NUM_FU);

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-to-arbiter request bus plus the registered CDB broadcast.
// master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_FU,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SRC_W   = $clog2(NUM_REQ)
);
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;
    logic [SRC_W-1:0]          grant_ptr;

    modport master (
        output flush, req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, grant_ptr
    );

    modport slave (
        input  flush, req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, grant_ptr
    );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Rotating priority encoder: first set bit of req at or after ptr,
// ascending and wrapping N-1 -> 0. Purely combinational.
module rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N = NUM_FU,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] cand;

    // Walk offsets 0..N-1 from ptr; N is a power of two so the W-bit add wraps.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + W'(k);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single CDB broadcast slot.
// Grants at most one producer per cycle and registers the winner's
// tag/data/source as next cycle's broadcast. Flush drops the grant.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_FU,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    // One broadcast slot; cdb_* outputs come straight from this register.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  src;
    } cdb_entry_t;

    cdb_entry_t         cdb_q;
    logic [SRC_W-1:0]   ptr_q;

    logic [NUM_REQ-1:0] win_onehot;
    logic [SRC_W-1:0]   win_idx;
    logic               win_any;
    logic               grant;
    logic [TAG_W-1:0]   win_tag;
    logic [DATA_W-1:0]  win_data;

    rr_picker #(
        .N (NUM_REQ),
        .W (SRC_W)
    ) u_picker (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // Reset and flush both veto the grant in the same cycle.
    assign grant         = win_any & ~bus.flush & ~rst;
    assign bus.req_ready = grant ? win_onehot : '0;

    // Winner select: only the one-hot lane is read, so junk or X on the
    // other producers' tag/data never reaches the broadcast register.
    always_comb begin
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_tag  = win_tag  | bus.req_tag[i*TAG_W +: TAG_W];
                win_data = win_data | bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Broadcast register and priority pointer. Payload holds while idle;
    // valid follows the grant so a flush cycle yields an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_q <= '0;
            ptr_q <= '0;
        end else begin
            cdb_q.valid <= grant;
            if (grant) begin
                cdb_q.tag  <= win_tag;
                cdb_q.data <= win_data;
                cdb_q.src  <= win_idx;
                ptr_q      <= win_idx + SRC_W'(1);
            end
        end
    end

    assign bus.cdb_valid = cdb_q.valid;
    assign bus.cdb_tag   = cdb_q.tag;
    assign bus.cdb_data  = cdb_q.data;
    assign bus.cdb_src   = cdb_q.src;
    assign bus.grant_ptr = ptr_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a random
// run, all compared against a round-robin reference model.
module tb_cdb_arbiter;
    localparam int NR = 8;
    localparam int TW = 3;
    localparam int DW = 32;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    cdb_arbiter_if #(.NUM_REQ(NR), .TAG_W(TW), .DATA_W(DW), .SRC_W(SW)) bus ();

    cdb_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .DATA_W(DW), .SRC_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: what the broadcast and pointer should be.
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_ptr;
    logic [SW-1:0] m_src;

    // First valid unit at or after p, wrapping; -1 when none.
    function automatic int pick(logic [NR-1:0] v, int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_ready();
        int w;
        if (rst || bus.flush) return '0;
        w = pick(bus.req_valid, int'(m_ptr));
        if (w < 0) return '0;
        return NR'(1) << w;
    endfunction

    function automatic logic [41:0] exp_cdb();
        return {m_valid, m_tag, m_data, m_src, m_ptr};
    endfunction

    function automatic logic [41:0] dut_cdb();
        return {bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src, bus.grant_ptr};
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_clock();
        int w;
        logic nv; logic [TW-1:0] nt; logic [DW-1:0] nd; logic [SW-1:0] ns, np;
        if (rst) begin
            nv = 0; nt = '0; nd = '0; ns = '0; np = '0;
        end else begin
            nv = 0; nt = m_tag; nd = m_data; ns = m_src; np = m_ptr;
            w = bus.flush ? -1 : pick(bus.req_valid, int'(m_ptr));
            if (w >= 0) begin
                nv = 1;
                nt = bus.req_tag[w*TW +: TW];
                nd = bus.req_data[w*DW +: DW];
                ns = SW'(w);
                np = SW'((w + 1) % NR);
            end
        end
        @(posedge clk);
        m_valid = nv; m_tag = nt; m_data = nd; m_src = ns; m_ptr = np;
        #1;
    endtask

    task automatic set_unit(int i, logic [TW-1:0] t, logic [DW-1:0] d);
        bus.req_tag[i*TW +: TW]  = t;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b1;
        for (int c = 0; c < 2; c++) begin
            bus.req_valid = NR'($urandom);
            @(negedge clk);
            n_tests++;
            if (bus.req_ready !== '0) begin
                n_fail++; $display("FAIL reset_ready: got %b want 0", bus.req_ready);
            end
            model_clock();
        end
        @(negedge clk);
        n_tests++;
        if (dut_cdb() !== 42'd0) begin
            n_fail++; $display("FAIL reset_state: got %h want 0", dut_cdb());
        end
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.req_valid = '0;
        model_clock();
    endtask

    task automatic test_single();
        bus.req_valid = 8'b0000_0100;
        set_unit(2, 3'd5, 32'hDEADBEEF);
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 8'b0000_0100) begin
            n_fail++; $display("FAIL single_ready: got %b want 00000100", bus.req_ready);
        end
        model_clock();
        bus.req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (dut_cdb() !== {1'b1, 3'd5, 32'hDEADBEEF, 3'd2, 3'd3}) begin
            n_fail++; $display("FAIL single_cdb: got %h want %h", dut_cdb(),
                               {1'b1, 3'd5, 32'hDEADBEEF, 3'd2, 3'd3});
        end
        model_clock();
    endtask

    task automatic test_all_valid();
        rst = 1'b1;
        model_clock();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_unit(i, TW'($urandom), $urandom);
        bus.req_valid = '1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.req_ready !== (NR'(1) << (k % NR))) begin
                n_fail++; $display("FAIL all_valid_ready[%0d]: got %b want %b", k,
                                   bus.req_ready, NR'(1) << (k % NR));
            end
            n_tests++;
            if (dut_cdb() !== exp_cdb()) begin
                n_fail++; $display("FAIL all_valid_cdb[%0d]: got %h want %h", k, dut_cdb(), exp_cdb());
            end
            model_clock();
            // The granted unit presents a fresh result.
            set_unit(k % NR, TW'($urandom), $urandom);
        end
        bus.req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (dut_cdb() !== exp_cdb()) begin
            n_fail++; $display("FAIL all_valid_tail: got %h want %h", dut_cdb(), exp_cdb());
        end
        model_clock();
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        model_clock();
        rst = 1'b0;
        bus.req_valid = 8'b0010_0000;
        model_clock();
        set_unit(6, 3'd6, 32'h6666_0006);
        set_unit(0, 3'd1, 32'h0000_0A0A);
        bus.req_valid = 8'b0100_0001;
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 8'b0100_0000 || bus.grant_ptr !== 3'd6) begin
            n_fail++; $display("FAIL wrap_first: got ready %b ptr %0d want 01000000 ptr 6",
                               bus.req_ready, bus.grant_ptr);
        end
        model_clock();
        bus.req_valid = 8'b0000_0001;
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 8'b0000_0001 || bus.grant_ptr !== 3'd7) begin
            n_fail++; $display("FAIL wrap_second: got ready %b ptr %0d want 00000001 ptr 7",
                               bus.req_ready, bus.grant_ptr);
        end
        model_clock();
        bus.req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (dut_cdb() !== {1'b1, 3'd1, 32'h0000_0A0A, 3'd0, 3'd1}) begin
            n_fail++; $display("FAIL wrap_cdb: got %h want %h", dut_cdb(),
                               {1'b1, 3'd1, 32'h0000_0A0A, 3'd0, 3'd1});
        end
        model_clock();
    endtask

    task automatic test_flush();
        logic [SW-1:0] ptr_before;
        set_unit(3, 3'd3, 32'h3333_3333);
        set_unit(4, 3'd4, 32'h4444_4444);
        bus.req_valid = 8'b0001_1000;
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== exp_ready() || bus.req_ready === '0) begin
            n_fail++; $display("FAIL flush_pre_ready: got %b want %b", bus.req_ready, exp_ready());
        end
        model_clock();
        bus.flush = 1'b1;
        ptr_before = bus.grant_ptr;
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== '0) begin
            n_fail++; $display("FAIL flush_ready: got %b want 0", bus.req_ready);
        end
        model_clock();
        bus.flush = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (bus.cdb_valid !== 1'b0 || bus.grant_ptr !== ptr_before) begin
            n_fail++; $display("FAIL flush_after: got valid %b ptr %0d want valid 0 ptr %0d",
                               bus.cdb_valid, bus.grant_ptr, ptr_before);
        end
        n_tests++;
        if (dut_cdb() !== exp_cdb()) begin
            n_fail++; $display("FAIL flush_model: got %h want %h", dut_cdb(), exp_cdb());
        end
        model_clock();
    endtask

    task automatic test_reset_midstream();
        bus.req_valid = '1;
        for (int c = 0; c < 3; c++) model_clock();
        @(negedge clk);
        n_tests++;
        if (bus.cdb_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got cdb_valid %b want 1", bus.cdb_valid);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== '0) begin
            n_fail++; $display("FAIL midrst_ready: got %b want 0", bus.req_ready);
        end
        model_clock();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_src !== 3'd0 || bus.grant_ptr !== 3'd0) begin
            n_fail++; $display("FAIL midrst_state: got valid %b src %0d ptr %0d want 0 0 0",
                               bus.cdb_valid, bus.cdb_src, bus.grant_ptr);
        end
        n_tests++;
        if (bus.req_ready !== 8'b0000_0001) begin
            n_fail++; $display("FAIL midrst_first: got %b want 00000001", bus.req_ready);
        end
        model_clock();
        bus.req_valid = '0;
        model_clock();
    endtask

    task automatic test_idle();
        logic [SW-1:0] ptr0;
        bus.req_valid = '0;
        ptr0 = bus.grant_ptr;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.req_ready !== '0 || bus.cdb_valid !== 1'b0 || bus.grant_ptr !== ptr0) begin
                n_fail++; $display("FAIL idle[%0d]: got ready %b valid %b ptr %0d want 0 0 %0d",
                                   c, bus.req_ready, bus.cdb_valid, bus.grant_ptr, ptr0);
            end
            model_clock();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = NR'($urandom);
            bus.flush     = ($urandom_range(7) == 0);
            rst           = ($urandom_range(63) == 0);
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid[i]) set_unit(i, TW'($urandom), $urandom);
                else                  set_unit(i, 'x, 'x);
            end
            @(negedge clk);
            n_tests++;
            if (bus.req_ready !== exp_ready()) begin
                n_fail++; $display("FAIL random_ready[%0d]: got %b want %b", c, bus.req_ready, exp_ready());
            end
            n_tests++;
            if (dut_cdb() !== exp_cdb()) begin
                n_fail++; $display("FAIL random_cdb[%0d]: got %h want %h", c, dut_cdb(), exp_cdb());
            end
            model_clock();
        end
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.req_valid = '0;
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        m_valid = 0; m_tag = '0; m_data = '0; m_src = '0; m_ptr = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_all_valid();
        test_wrap();
        test_flush();
        test_reset_midstream();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
